sweep_peak_tracker: RTL and testbench

Scan controller that drives the panel servo angle (theta) across a range, samples the ADC at each angle once the servo has settled, and records the largest averaged voltage together with the angle where it occurred. It sits between the raw 12-bit ADC bus and the max/display stages. When the sweep finishes it parks the servo at the best angle and presents max_value/max_theta to the BCD/7-seg path.

---
 rtl/sweep_peak_tracker_pkg.sv | 19 +
 rtl/sweep_peak_tracker_sample_averager.sv | 43 ++++
 rtl/sweep_peak_tracker.sv | 144 ++++++++++++++
 tb/tb_sweep_peak_tracker.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_peak_tracker_pkg.sv
// Shared types and default widths for the sweep/max/display path.
// Holds the sweep FSM state encoding and the default bus widths.
package sweep_peak_tracker_pkg;

  localparam int DEF_DATA_W  = 12;
  localparam int DEF_ANGLE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_SAMPLE,
    S_COMPARE,
    S_NEXT,
    S_PARK,
    S_DONE
  } state_t;

endpackage

// File: rtl/sweep_peak_tracker_sample_averager.sv
// Accumulates 2^AVG_LOG2 valid ADC samples and presents their mean.
// Ports: clk, reset (async low), clear, enable, sample/sample_valid in; avg, full out.
module sample_averager
  import sweep_peak_tracker_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] avg,
  output logic              full
);

  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;

  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt;

  assign full = (cnt == CNT_W'(NSAMP));
  // Dropping the low bits is the truncating divide.
  assign avg  = sum[SUM_W-1 -: DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
      cnt <= '0;
    end else if (clear) begin
      sum <= '0;
      cnt <= '0;
    end else if (enable && sample_valid && !full) begin
      sum <= sum + SUM_W'(sample);
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sweep_peak_tracker.sv
// Sweeps the servo angle, averages ADC samples per angle, parks at the peak.
// Ports: clk, reset, start, adc_value/adc_valid in; theta, busy, done, max_value, max_theta out.
module sweep_peak_tracker
  import sweep_peak_tracker_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ANGLE_W    = DEF_ANGLE_W,
  parameter int ANGLE_MIN  = 0,
  parameter int ANGLE_MAX  = 180,
  parameter int ANGLE_STEP = 5,
  parameter int SETTLE_CYC = 50000,
  parameter int AVG_LOG2   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  adc_value,
  input  logic               adc_valid,
  output logic [ANGLE_W-1:0] theta,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  max_value,
  output logic [ANGLE_W-1:0] max_theta
);

  if (ANGLE_MIN > ANGLE_MAX || ANGLE_MAX >= (1 << ANGLE_W) ||
      ANGLE_STEP < 1 || SETTLE_CYC < 1) begin : g_bad_cfg
    $error("sweep_peak_tracker: illegal parameter set");
  end

  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [ANGLE_W-1:0] A_MIN  = ANGLE_W'(ANGLE_MIN);
  localparam logic [ANGLE_W-1:0] A_STEP = ANGLE_W'(ANGLE_STEP);
  localparam logic [ANGLE_W:0]   A_MAXW = (ANGLE_W+1)'(ANGLE_MAX);
  localparam logic [ANGLE_W:0]   A_STPW = (ANGLE_W+1)'(ANGLE_STEP);
  localparam logic [SET_W-1:0]   SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_t             state;
  state_t             state_nxt;
  logic [SET_W-1:0]   settle_cnt;
  logic [DATA_W-1:0]  best_val;
  logic [ANGLE_W-1:0] best_theta;
  logic [DATA_W-1:0]  avg;
  logic               avg_full;
  logic               avg_clear;
  logic               avg_en;
  logic [ANGLE_W:0]   step_sum;
  logic               past_max;

  // One extra bit so an angle near 2^ANGLE_W cannot wrap back to 0.
  assign step_sum = {1'b0, theta} + A_STPW;
  assign past_max = (step_sum > A_MAXW);

  sample_averager #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .reset        (reset),
    .clear        (avg_clear),
    .enable       (avg_en),
    .sample       (adc_value),
    .sample_valid (adc_valid),
    .avg          (avg),
    .full         (avg_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    avg_clear = 1'b0;
    avg_en    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_MOVE;
      end
      S_MOVE: state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt == SET_LAST) begin
          state_nxt = S_SAMPLE;
          avg_clear = 1'b1;
        end
      end
      S_SAMPLE: begin
        avg_en = 1'b1;
        if (avg_full) state_nxt = S_COMPARE;
      end
      S_COMPARE: state_nxt = S_NEXT;
      S_NEXT: state_nxt = past_max ? S_PARK : S_MOVE;
      S_PARK: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      theta      <= A_MIN;
      busy       <= 1'b0;
      done       <= 1'b0;
      max_value  <= '0;
      max_theta  <= A_MIN;
      best_val   <= '0;
      best_theta <= A_MIN;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            theta      <= A_MIN;
            best_val   <= '0;
            best_theta <= A_MIN;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_MOVE: settle_cnt <= '0;
        S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        S_COMPARE: begin
          // Strict compare keeps the earliest angle on ties.
          if (avg > best_val) begin
            best_val   <= avg;
            best_theta <= theta;
          end
        end
        S_NEXT: begin
          if (!past_max) theta <= theta + A_STEP;
        end
        S_PARK: begin
          theta     <= best_theta;
          max_value <= best_val;
          max_theta <= best_theta;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_peak_tracker.sv
// Scoreboard bench for sweep_peak_tracker across three angle configurations.
// A servo/ADC model drives each DUT; a monitor checks each finished sweep.
module tb_sweep_peak_tracker;

  localparam int SETTLE = 4;

  typedef struct {
    int dut;
    int mv;
    int mt;
    int n;
    int ang[16];
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic [2:0]  done_v;
  logic [2:0]  busy_v;
  int          vmode [3];
  logic [11:0] samp [3][256][4];
  exp_t        expq[$];
  int          tests = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int amax(input int g);
    return (g == 0) ? 180 : ((g == 1) ? 170 : 255);
  endfunction

  function automatic int astep(input int g);
    return (g == 2) ? 85 : 45;
  endfunction

  // Reference: visit angles min..max by step, mean of 4, keep strict best.
  function automatic exp_t ref_model(input int g);
    exp_t e;
    int best;
    int bt;
    int sum;
    best = 0;
    bt = 0;
    e.dut = g;
    e.n = 0;
    for (int i = 0; i < 16; i++) e.ang[i] = 0;
    for (int a = 0; a <= amax(g); a += astep(g)) begin
      sum = 0;
      for (int k = 0; k < 4; k++) sum += int'(samp[g][a][k]);
      if (sum / 4 > best) begin
        best = sum / 4;
        bt = a;
      end
      e.ang[e.n] = a;
      e.n++;
    end
    e.mv = best;
    e.mt = bt;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [11:0] adc_value;
    logic        adc_valid;
    logic [7:0]  theta;
    logic        busy;
    logic        done;
    logic [11:0] max_value;
    logic [7:0]  max_theta;

    sweep_peak_tracker #(
      .DATA_W     (12),
      .ANGLE_W    (8),
      .ANGLE_MIN  (0),
      .ANGLE_MAX  ((g == 0) ? 180 : ((g == 1) ? 170 : 255)),
      .ANGLE_STEP ((g == 2) ? 85 : 45),
      .SETTLE_CYC (SETTLE),
      .AVG_LOG2   (2)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start_v[g]),
      .adc_value (adc_value),
      .adc_valid (adc_valid),
      .theta     (theta),
      .busy      (busy),
      .done      (done),
      .max_value (max_value),
      .max_theta (max_theta)
    );

    assign done_v[g] = done;
    assign busy_v[g] = busy;

    // Servo/ADC model: 4095 until the servo has settled and after 4 valid samples.
    int         cnt;
    int         k;
    logic       tog;
    logic [7:0] pth;
    logic       pb;
    always @(negedge clk) begin
      if (!reset) begin
        cnt = 0;
        k = 0;
        tog = 1'b0;
        pth = 8'd0;
        pb = 1'b0;
        adc_valid = 1'b0;
        adc_value = 12'd0;
      end else begin
        if (theta != pth || (busy && !pb)) begin
          cnt = 0;
          k = 0;
        end
        pth = theta;
        pb = busy;
        tog = !tog;
        adc_valid = (vmode[g] != 0) ? tog : 1'b1;
        if (cnt < SETTLE + 1 || k >= 4) begin
          adc_value = 12'hFFF;
        end else begin
          adc_value = samp[g][theta][k];
          if (adc_valid) k++;
        end
        if (cnt < 1000) cnt++;
      end
    end

    int         seen[$];
    logic [7:0] mth;
    logic       mpb;
    logic       mpd;
    exp_t       e;
    always @(negedge clk) begin
      if (!reset) begin
        seen.delete();
        mth = 8'd0;
        mpb = 1'b0;
        mpd = 1'b0;
      end else begin
        if (busy && (theta != mth || !mpb)) seen.push_back(int'(theta));
        if (done && !mpd) begin
          if (expq.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_done dut%0d: got done=1, expected none", g);
          end else begin
            e = expq.pop_front();
            chk($sformatf("dut%0d_sb_owner", g), g, e.dut);
            chk($sformatf("dut%0d_max_value", g), int'(max_value), e.mv);
            chk($sformatf("dut%0d_max_theta", g), int'(max_theta), e.mt);
            chk($sformatf("dut%0d_park_theta", g), int'(theta), e.mt);
            chk($sformatf("dut%0d_busy_at_done", g), int'(busy), 0);
            chk($sformatf("dut%0d_busy_before_done", g), int'(mpb), 1);
            chk($sformatf("dut%0d_angle_count", g), seen.size(), e.n);
            for (int i = 0; i < e.n && i < seen.size(); i++)
              chk($sformatf("dut%0d_angle%0d", g, i), seen[i], e.ang[i]);
          end
          seen.delete();
        end
        mth = theta;
        mpb = busy;
        mpd = done;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int g);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int c;
    c = 0;
    while (!done_v[g] && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("dut%0d_done_in_time", g), int'(done_v[g]), 1);
    tick(2);
  endtask

  task automatic run_sweep(input int g, input int poke);
    expq.push_back(ref_model(g));
    pulse_start(g);
    if (poke != 0) begin
      tick(10);
      pulse_start(g);
    end
    wait_done(g);
  endtask

  task automatic fill_rand(input int g, input int lim);
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 4; k++)
        samp[g][a][k] = 12'($urandom_range(0, lim));
  endtask

  task automatic fill_zero(input int g);
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 4; k++)
        samp[g][a][k] = 12'd0;
  endtask

  initial begin
    int bad;
    int oldmv;
    int c;
    int pk[5];
    exp_t e;
    reset = 1'b0;
    start_v = 3'b000;
    for (int g = 0; g < 3; g++) begin
      vmode[g] = 0;
      fill_zero(g);
    end
    tick(3);
    reset = 1'b1;

    chk("rst_theta", int'(g_dut[0].theta), 0);
    chk("rst_busy", int'(g_dut[0].busy), 0);
    chk("rst_done", int'(g_dut[0].done), 0);
    chk("rst_max_value", int'(g_dut[0].max_value), 0);
    chk("rst_max_theta", int'(g_dut[0].max_theta), 0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (g_dut[0].theta != 0 || busy_v != 0 || done_v != 0 ||
          g_dut[0].max_value != 0 || g_dut[0].max_theta != 0) bad++;
    end
    chk("idle_stable", bad, 0);

    pk = '{100, 300, 900, 400, 200};
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++) samp[0][i * 45][k] = 12'(pk[i]);
    run_sweep(0, 0);
    chk("peak_value_direct", int'(g_dut[0].max_value), 900);

    fill_zero(0);
    samp[0][45][0] = 12'd10;
    samp[0][45][1] = 12'd11;
    samp[0][45][2] = 12'd12;
    samp[0][45][3] = 12'd13;
    samp[0][90][0] = 12'd9;
    samp[0][90][1] = 12'd12;
    samp[0][90][2] = 12'd11;
    samp[0][90][3] = 12'd12;
    run_sweep(0, 0);
    chk("tie_theta_direct", int'(g_dut[0].max_theta), 45);

    vmode[0] = 1;
    fill_rand(0, 4000);
    run_sweep(0, 1);

    e = ref_model(0);
    oldmv = int'(g_dut[0].max_value);
    chk("done_before_restart", int'(done_v[0]), 1);
    fill_rand(0, 2000);
    expq.push_back(ref_model(0));
    pulse_start(0);
    chk("restart_done_clear", int'(done_v[0]), 0);
    chk("restart_busy", int'(busy_v[0]), 1);
    tick(20);
    chk("restart_hold_max", int'(g_dut[0].max_value), oldmv);
    chk("restart_old_expected", oldmv, e.mv);
    wait_done(0);

    vmode[1] = 0;
    fill_rand(1, 4095);
    run_sweep(1, 0);
    vmode[2] = 1;
    fill_rand(2, 4095);
    run_sweep(2, 0);

    for (int i = 0; i < 6; i++) begin
      vmode[i % 3] = int'($urandom_range(0, 1));
      fill_rand(i % 3, (i < 3) ? 7 : 4095);
      run_sweep(i % 3, i & 1);
    end

    vmode[0] = 0;
    fill_rand(0, 4095);
    samp[0][0][0] = 12'd4000;
    pulse_start(0);
    c = 0;
    while (g_dut[0].theta != 8'd90 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("abort_reach_90", int'(g_dut[0].theta), 90);
    tick(7);
    #2 reset = 1'b0;
    #1;
    chk("abort_theta", int'(g_dut[0].theta), 0);
    chk("abort_busy", int'(g_dut[0].busy), 0);
    chk("abort_done", int'(g_dut[0].done), 0);
    chk("abort_max_value", int'(g_dut[0].max_value), 0);
    chk("abort_max_theta", int'(g_dut[0].max_theta), 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("post_abort_idle", int'(busy_v[0]), 0);
    fill_rand(0, 4095);
    run_sweep(0, 0);

    chk("scoreboard_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
